// File: rtl/regfile_pkg.sv
// Shared defaults and bus-slicing helper for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NREAD_DEF  = 2;
  localparam int unsigned NWRITE     = 2;

  // Bit offset of lane idx inside a flattened bus of width-bit lanes.
  function automatic int unsigned sliceOff(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: array mux, write-through bypass, R0 masking
// and busy qualification.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned R0_ZERO = 1
) (
  input  logic                      rstN,
  input  logic [DATA_W-1:0]         mem [1 << ADDR_W],
  input  logic [(1 << ADDR_W)-1:0]  busy,
  input  logic [ADDR_W-1:0]         rdAddr,
  input  logic [1:0]                wrEn,
  input  logic [ADDR_W-1:0]         wrAddr0,
  input  logic [ADDR_W-1:0]         wrAddr1,
  input  logic [DATA_W-1:0]         wrData0,
  input  logic [DATA_W-1:0]         wrData1,
  input  logic                      rsvEn,
  input  logic [ADDR_W-1:0]         rsvAddr,
  output logic [DATA_W-1:0]         rdData,
  output logic                      rdBusy
);

  localparam bit R0 = (R0_ZERO != 0);

  logic              hit0;
  logic              hit1;
  logic              rsvHit;
  logic              isZero;
  logic [DATA_W-1:0] data;

  always_comb begin
    hit0   = wrEn[0] && (wrAddr0 == rdAddr);
    hit1   = wrEn[1] && (wrAddr1 == rdAddr);
    rsvHit = rsvEn && (rsvAddr == rdAddr);
    isZero = R0 && (rdAddr == '0);

    // Port 1 checked last so it overrides port 0 on a double hit.
    data = mem[rdAddr];
    if (hit0) data = wrData0;
    if (hit1) data = wrData1;

    rdData = (!rstN || isZero) ? '0 : data;
    rdBusy = rstN && !isZero && busy[rdAddr] && !((hit0 || hit1) && !rsvHit);
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with a per-register busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned NREAD   = NREAD_DEF,
  parameter int unsigned R0_ZERO = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREAD*ADDR_W-1:0]    rd_addr,
  output logic [NREAD*DATA_W-1:0]    rd_data,
  output logic [NREAD-1:0]           rd_busy,
  input  logic [NWRITE-1:0]          wr_en,
  input  logic [NWRITE*ADDR_W-1:0]   wr_addr,
  input  logic [NWRITE*DATA_W-1:0]   wr_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam bit          R0    = (R0_ZERO != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busyNext;

  logic [ADDR_W-1:0] wrAddr0;
  logic [ADDR_W-1:0] wrAddr1;
  logic [DATA_W-1:0] wrData0;
  logic [DATA_W-1:0] wrData1;
  logic [1:0]        wrAccept;
  logic              rsvAccept;

  assign wrAddr0 = wr_addr[sliceOff(0, ADDR_W) +: ADDR_W];
  assign wrAddr1 = wr_addr[sliceOff(1, ADDR_W) +: ADDR_W];
  assign wrData0 = wr_data[sliceOff(0, DATA_W) +: DATA_W];
  assign wrData1 = wr_data[sliceOff(1, DATA_W) +: DATA_W];

  assign wrAccept[0] = wr_en[0] && !(R0 && (wrAddr0 == '0));
  assign wrAccept[1] = wr_en[1] && !(R0 && (wrAddr1 == '0));
  assign rsvAccept   = rsv_en && !(R0 && (rsv_addr == '0));

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wrAccept[0]) mem[wrAddr0] <= wrData0;
      if (wrAccept[1]) mem[wrAddr1] <= wrData1;
    end
  end

  always_comb begin
    busyNext = busy;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rsvAccept && (rsv_addr == ADDR_W'(i))) begin
        busyNext[i] = 1'b1;
      end else if ((wrAccept[0] && (wrAddr0 == ADDR_W'(i))) ||
                   (wrAccept[1] && (wrAddr1 == ADDR_W'(i)))) begin
        busyNext[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busyNext;
  end

  for (genvar k = 0; k < NREAD; k++) begin : gRd
    regfile_rdport #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .R0_ZERO (R0_ZERO)
    ) uRdPort (
      .rstN    (rst_n),
      .mem     (mem),
      .busy    (busy),
      .rdAddr  (rd_addr[sliceOff(k, ADDR_W) +: ADDR_W]),
      .wrEn    (wr_en),
      .wrAddr0 (wrAddr0),
      .wrAddr1 (wrAddr1),
      .wrData0 (wrData0),
      .wrData1 (wrData1),
      .rsvEn   (rsv_en),
      .rsvAddr (rsv_addr),
      .rdData  (rd_data[sliceOff(k, DATA_W) +: DATA_W]),
      .rdBusy  (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: one R0-zero instance and one plain instance
// driven in parallel, expectations queued at drive time and drained each cycle.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  rdAddr = '0;
  logic [63:0] rdDataZ, rdDataN;
  logic [1:0]  rdBusyZ, rdBusyN;
  logic [1:0]  wrEn = '0;
  logic [9:0]  wrAddr = '0;
  logic [63:0] wrData = '0;
  logic        rsvEn = 1'b0;
  logic [4:0]  rsvAddr = '0;

  int nChecks = 0;
  int nErrors = 0;
  int cyc = 0;

  // Model: index 0 tracks the R0_ZERO=1 instance, index 1 the R0_ZERO=0 one.
  logic [31:0] mdl [2][32];
  logic        bsy [2][32];

  typedef struct {
    string       tag;
    int          m;
    int          kind;
    int          port;
    logic [31:0] val;
  } expT;
  expT sb[$];

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .R0_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rdAddr), .rd_data(rdDataZ), .rd_busy(rdBusyZ),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .rsv_en(rsvEn), .rsv_addr(rsvAddr)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .R0_ZERO(0)) dutNz (
    .clk(clk), .rst_n(rst_n), .rd_addr(rdAddr), .rd_data(rdDataN), .rd_busy(rdBusyN),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .rsv_en(rsvEn), .rsv_addr(rsvAddr)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expData(input int m, input logic [4:0] a);
    logic [31:0] v;
    if (!rst_n) return '0;
    if (m == 0 && a == 5'd0) return '0;
    v = mdl[m][a];
    if (wrEn[0] && wrAddr[4:0] == a) v = wrData[31:0];
    if (wrEn[1] && wrAddr[9:5] == a) v = wrData[63:32];
    return v;
  endfunction

  function automatic logic expBusy(input int m, input logic [4:0] a);
    logic wHit;
    if (!rst_n) return 1'b0;
    if (m == 0 && a == 5'd0) return 1'b0;
    wHit = (wrEn[0] && wrAddr[4:0] == a) || (wrEn[1] && wrAddr[9:5] == a);
    if (wHit && !(rsvEn && rsvAddr == a)) return 1'b0;
    return bsy[m][a];
  endfunction

  task automatic clearModel();
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 32; a++) begin
        mdl[m][a] = '0;
        bsy[m][a] = 1'b0;
      end
  endtask

  // Applied in write-then-reserve order so a same-cycle reserve leaves busy set.
  task automatic updateModel();
    if (!rst_n) begin
      clearModel();
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (wrEn[0] && !(m == 0 && wrAddr[4:0] == 5'd0)) begin
          mdl[m][wrAddr[4:0]] = wrData[31:0];
          bsy[m][wrAddr[4:0]] = 1'b0;
        end
        if (wrEn[1] && !(m == 0 && wrAddr[9:5] == 5'd0)) begin
          mdl[m][wrAddr[9:5]] = wrData[63:32];
          bsy[m][wrAddr[9:5]] = 1'b0;
        end
        if (rsvEn && !(m == 0 && rsvAddr == 5'd0)) bsy[m][rsvAddr] = 1'b1;
      end
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] we,
                      input logic [4:0] wa0, input logic [31:0] wd0,
                      input logic [4:0] wa1, input logic [31:0] wd1,
                      input logic rsv, input logic [4:0] rsa,
                      input logic [4:0] ra0, input logic [4:0] ra1);
    logic [4:0]  ra [2];
    logic [31:0] obs;
    expT         e;
    rst_n   = rst;
    wrEn    = we;
    wrAddr  = {wa1, wa0};
    wrData  = {wd1, wd0};
    rsvEn   = rsv;
    rsvAddr = rsa;
    rdAddr  = {ra1, ra0};
    ra[0] = ra0;
    ra[1] = ra1;
    for (int m = 0; m < 2; m++)
      for (int p = 0; p < 2; p++) begin
        sb.push_back('{$sformatf("c%0d m%0d data%0d a%0d", cyc, m, p, ra[p]), m, 0, p, expData(m, ra[p])});
        sb.push_back('{$sformatf("c%0d m%0d busy%0d a%0d", cyc, m, p, ra[p]), m, 1, p, {31'b0, expBusy(m, ra[p])}});
      end
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.m == 0) obs = (e.kind == 0) ? rdDataZ[e.port*32 +: 32] : {31'b0, rdBusyZ[e.port]};
      else          obs = (e.kind == 0) ? rdDataN[e.port*32 +: 32] : {31'b0, rdBusyN[e.port]};
      checkEq(e.tag, obs, e.val);
    end
    updateModel();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic readOnly(input logic [4:0] ra0, input logic [4:0] ra1);
    step(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, ra0, ra1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clearModel();
    @(posedge clk);
    #1;
    // Reset held: writes and reserves must be ignored, outputs zero.
    step(1'b0, 2'b11, 5'd4, 32'h1234, 5'd6, 32'h5678, 1'b1, 5'd4, 5'd4, 5'd6);

    for (int a = 0; a < 32; a++) readOnly(5'(a), 5'(31 - a));

    // Port 0 write with same-cycle bypass, then stored read.
    step(1'b1, 2'b01, 5'd3, 32'h0000_0008, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
    readOnly(5'd3, 5'd3);

    // Dual write collision: port 1 wins in bypass and storage.
    step(1'b1, 2'b11, 5'd5, 32'h11, 5'd5, 32'h22, 1'b0, 5'd0, 5'd5, 5'd3);
    readOnly(5'd5, 5'd5);

    // Register 0 behaviour, bypass from both ports.
    step(1'b1, 2'b01, 5'd0, 32'hDEAD_BEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd1);
    readOnly(5'd0, 5'd0);
    step(1'b1, 2'b10, 5'd0, 32'h0, 5'd0, 32'hCAFE_F00D, 1'b1, 5'd0, 5'd0, 5'd0);
    readOnly(5'd0, 5'd0);

    // Scoreboard: reserve, clear by write, reserve-wins collisions.
    step(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7);
    readOnly(5'd7, 5'd7);
    step(1'b1, 2'b01, 5'd7, 32'h2, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
    readOnly(5'd7, 5'd7);
    step(1'b1, 2'b10, 5'd0, 32'h0, 5'd7, 32'h3, 1'b1, 5'd7, 5'd7, 5'd7);
    readOnly(5'd7, 5'd7);
    step(1'b1, 2'b01, 5'd7, 32'h4, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd8);
    readOnly(5'd7, 5'd7);

    // Asynchronous reset mid-sequence drops data and the pending reservation.
    step(1'b1, 2'b01, 5'd9, 32'h55, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd7);
    step(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9);
    readOnly(5'd9, 5'd7);
    step(1'b0, 2'b01, 5'd9, 32'h77, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd7);
    step(1'b1, 2'b01, 5'd10, 32'hA5, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd10);
    readOnly(5'd10, 5'd9);

    // Random traffic over a narrow address window to force collisions.
    for (int i = 0; i < 150; i++) begin
      step(1'b1, 2'($urandom_range(0, 3)),
           5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
